// File: rtl/mux_sel_stage.sv
// Registered, flow-controlled NSRC-to-1 word selector with valid/ready handshake.
// Define MUX_SEL_STAGE_SKID_EN for a two-entry skid stage with registered in_ready.
module mux_sel_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NSRC  = 4,
    localparam int unsigned SELW = $clog2(NSRC)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NSRC*WIDTH-1:0]   I,
    input  logic [SELW-1:0]         s,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [WIDTH-1:0]        o,
    output logic                    o_err
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic             accept;

    // Out-of-range selects yield a zero word flagged as an error.
    always_comb begin
        sel_data = '0;
        sel_err  = 1'b1;
        for (int unsigned k = 0; k < NSRC; k++) begin
            if (32'(s) == k) begin
                sel_data = I[k*WIDTH +: WIDTH];
                sel_err  = 1'b0;
            end
        end
    end

    assign accept = in_valid && in_ready;

`ifdef MUX_SEL_STAGE_SKID_EN

    logic [WIDTH-1:0] sk_data;
    logic             sk_err;
    logic             sk_valid;

    // Depends only on state and rst, so o_ready never reaches the producer combinationally.
    assign in_ready = !rst && !sk_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            o        <= '0;
            o_err    <= 1'b0;
            o_valid  <= 1'b0;
            sk_data  <= '0;
            sk_err   <= 1'b0;
            sk_valid <= 1'b0;
        end else if (flush) begin
            o_valid  <= 1'b0;
            sk_valid <= 1'b0;
        end else if (!o_valid || o_ready) begin
            if (sk_valid) begin
                o        <= sk_data;
                o_err    <= sk_err;
                o_valid  <= 1'b1;
                sk_valid <= 1'b0;
            end else begin
                o_valid <= accept;
                if (accept) begin
                    o     <= sel_data;
                    o_err <= sel_err;
                end
            end
        end else if (accept) begin
            sk_data  <= sel_data;
            sk_err   <= sel_err;
            sk_valid <= 1'b1;
        end
    end

`else

    assign in_ready = !rst && (!o_valid || o_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            o       <= '0;
            o_err   <= 1'b0;
            o_valid <= 1'b0;
        end else if (flush) begin
            o_valid <= 1'b0;
        end else if (!o_valid || o_ready) begin
            o_valid <= accept;
            if (accept) begin
                o     <= sel_data;
                o_err <= sel_err;
            end
        end
    end

`endif

endmodule

// File: tb/tb_mux_sel_stage.sv
// Directed self-checking bench for mux_sel_stage (NSRC=4 main instance, NSRC=3 range instance).
// Expectations follow MUX_SEL_STAGE_SKID_EN when it is defined.
module tb_mux_sel_stage;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] I;
    logic [1:0]   s;
    logic         o_valid;
    logic         o_ready;
    logic [31:0]  o;
    logic         o_err;

    logic         in_valid2;
    logic         in_ready2;
    logic [95:0]  I2;
    logic [1:0]   s2;
    logic         o_valid2;
    logic         o_ready2;
    logic [31:0]  o2;
    logic         o_err2;

    int n_cmp = 0;
    int n_bad = 0;

    mux_sel_stage #(.WIDTH(32), .NSRC(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .I(I), .s(s),
        .o_valid(o_valid), .o_ready(o_ready), .o(o), .o_err(o_err)
    );

    mux_sel_stage #(.WIDTH(32), .NSRC(3)) dut3 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid2), .in_ready(in_ready2), .I(I2), .s(s2),
        .o_valid(o_valid2), .o_ready(o_ready2), .o(o2), .o_err(o_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (o !== 32'h0) begin n_bad++; $display("FAIL reset_o: got %h want %h", o, 32'h0); end
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", o_err); end
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (o_valid2 !== 1'b0) begin n_bad++; $display("FAIL reset_valid2: got %b want 0", o_valid2); end
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (in_ready2 !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready2: got %b want 1", in_ready2); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h00000000;
        exp_w[1] = 32'h11111111;
        exp_w[2] = 32'h22222222;
        exp_w[3] = 32'h33333333;
        I = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
        in_valid = 1'b1;
        o_ready  = 1'b1;
        s        = 2'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
            tick();
            n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d]: got %b want 1", i, o_valid); end
            n_cmp++; if (o !== exp_w[i]) begin n_bad++; $display("FAIL stream_o[%0d]: got %h want %h", i, o, exp_w[i]); end
            n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL stream_err[%0d]: got %b want 0", i, o_err); end
            s = 2'(i + 1);
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL stream_idle_valid: got %b want 0", o_valid); end
    endtask

    task automatic test_out_of_range();
        I2 = {32'h22222222, 32'h12345678, 32'hDEADBEEF};
        in_valid2 = 1'b1;
        s2 = 2'd3;
        tick();
        n_cmp++; if (o2 !== 32'h0) begin n_bad++; $display("FAIL oor_o: got %h want %h", o2, 32'h0); end
        n_cmp++; if (o_err2 !== 1'b1) begin n_bad++; $display("FAIL oor_err: got %b want 1", o_err2); end
        n_cmp++; if (o_valid2 !== 1'b1) begin n_bad++; $display("FAIL oor_valid: got %b want 1", o_valid2); end
        s2 = 2'd2;
        tick();
        n_cmp++; if (o2 !== 32'h22222222) begin n_bad++; $display("FAIL top_src_o: got %h want %h", o2, 32'h22222222); end
        n_cmp++; if (o_err2 !== 1'b0) begin n_bad++; $display("FAIL top_src_err: got %b want 0", o_err2); end
        s2 = 2'd0;
        tick();
        n_cmp++; if (o2 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL src0_o: got %h want %h", o2, 32'hDEADBEEF); end
        in_valid2 = 1'b0;
        tick();
        n_cmp++; if (o_valid2 !== 1'b0) begin n_bad++; $display("FAIL oor_idle_valid: got %b want 0", o_valid2); end
    endtask

    task automatic test_stall();
        I = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        in_valid = 1'b1;
        o_ready  = 1'b1;
        s = 2'd0;
        tick();
        n_cmp++; if (o !== 32'hAAAAAAAA) begin n_bad++; $display("FAIL stall_a: got %h want %h", o, 32'hAAAAAAAA); end
        s = 2'd1;
        tick();
        n_cmp++; if (o !== 32'hBBBBBBBB) begin n_bad++; $display("FAIL stall_b: got %h want %h", o, 32'hBBBBBBBB); end
        o_ready = 1'b0;
        s = 2'd2;
`ifdef MUX_SEL_STAGE_SKID_EN
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_ready_pre: got %b want 1", in_ready); end
        tick();
        n_cmp++; if (o !== 32'hBBBBBBBB || o_valid !== 1'b1) begin n_bad++; $display("FAIL stall_hold_b: got %h/%b want %h/1", o, o_valid, 32'hBBBBBBBB); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready_low: got %b want 0", in_ready); end
        o_ready  = 1'b1;
        in_valid = 1'b0;
        tick();
        n_cmp++; if (o !== 32'hCCCCCCCC || o_valid !== 1'b1) begin n_bad++; $display("FAIL stall_c: got %h/%b want %h/1", o, o_valid, 32'hCCCCCCCC); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_ready_back: got %b want 1", in_ready); end
`else
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready_comb: got %b want 0", in_ready); end
        tick();
        n_cmp++; if (o !== 32'hBBBBBBBB || o_valid !== 1'b1) begin n_bad++; $display("FAIL stall_hold_b: got %h/%b want %h/1", o, o_valid, 32'hBBBBBBBB); end
        o_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_ready_back: got %b want 1", in_ready); end
        tick();
        n_cmp++; if (o !== 32'hCCCCCCCC || o_valid !== 1'b1) begin n_bad++; $display("FAIL stall_c: got %h/%b want %h/1", o, o_valid, 32'hCCCCCCCC); end
        in_valid = 1'b0;
`endif
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL stall_drained: got %b want 0", o_valid); end
    endtask

    task automatic test_back_to_back();
        int acc;
        int exp_acc;
`ifdef MUX_SEL_STAGE_SKID_EN
        exp_acc = 2;
`else
        exp_acc = 1;
`endif
        acc = 0;
        o_ready  = 1'b0;
        in_valid = 1'b1;
        for (int j = 0; j < 5; j++) begin
            s = 2'(j);
            #1;
            if (in_ready && in_valid) acc++;
            tick();
        end
        n_cmp++; if (acc !== exp_acc) begin n_bad++; $display("FAIL full_accept_count: got %0d want %0d", acc, exp_acc); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (o !== 32'hAAAAAAAA || o_valid !== 1'b1) begin n_bad++; $display("FAIL full_head: got %h/%b want %h/1", o, o_valid, 32'hAAAAAAAA); end
        in_valid = 1'b0;
        o_ready  = 1'b1;
`ifdef MUX_SEL_STAGE_SKID_EN
        tick();
        n_cmp++; if (o !== 32'hBBBBBBBB || o_valid !== 1'b1) begin n_bad++; $display("FAIL full_second: got %h/%b want %h/1", o, o_valid, 32'hBBBBBBBB); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_after: got %b want 1", in_ready); end
`endif
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL full_drained: got %b want 0", o_valid); end
    endtask

    task automatic test_flush();
        o_ready  = 1'b0;
        in_valid = 1'b1;
        s = 2'd0;
        tick();
        s = 2'd1;
        tick();
        flush   = 1'b1;
        o_ready = 1'b1;
        s = 2'd2;
`ifndef MUX_SEL_STAGE_SKID_EN
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_offer_ready: got %b want 1", in_ready); end
`endif
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", o_valid); end
        n_cmp++; if (o !== 32'hAAAAAAAA) begin n_bad++; $display("FAIL flush_o_kept: got %h want %h", o, 32'hAAAAAAAA); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_delivery: got %b want 0", o_valid); end
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_delivery2: got %b want 0", o_valid); end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        o_ready  = 1'b1;
        s = 2'd3;
        tick();
        n_cmp++; if (o !== 32'hDDDDDDDD || o_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_pre: got %h/%b want %h/1", o, o_valid, 32'hDDDDDDDD); end
        rst = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_ready_in_rst: got %b want 0", in_ready); end
        tick();
        n_cmp++; if (o !== 32'h0 || o_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_cleared: got %h/%b want %h/0", o, o_valid, 32'h0); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_ready_held: got %b want 0", in_ready); end
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready_after: got %b want 1", in_ready); end
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_no_delivery: got %b want 0", o_valid); end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        o_ready   = 1'b1;
        I         = '0;
        s         = '0;
        in_valid2 = 1'b0;
        o_ready2  = 1'b1;
        I2        = '0;
        s2        = '0;
        test_reset();
        test_stream();
        test_out_of_range();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
